connect4_win_checker: RTL and testbench

- Responder for the top controller's check handshake. It accepts check_en and returns check_finish and check_4.
- While check_en is high it reads the board one row per cycle through the board-memory read port. The controller's row_addr_sel grants this port to the checker.
- It detects four-in-a-row of the player who just moved, horizontally, vertically or diagonally.
- On a win it aborts the scan early and reports the anchor cell and direction so the display path can highlight the line.

---
 rtl/connect4_win_checker_pkg.sv | 31 +++
 rtl/connect4_win_checker_if.sv | 28 ++
 rtl/connect4_line_detect.sv | 74 +++++++
 rtl/connect4_win_checker.sv | 130 +++++++++++++
 tb/tb_connect4_win_checker.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/connect4_win_checker_pkg.sv
// rtl/connect4_win_checker_pkg.sv - shared codes, defaults and state encoding for the win checker
package connect4_win_checker_pkg;

    localparam int DEF_ROWS = 6;
    localparam int DEF_COLS = 7;
    localparam int DEF_RAW  = 3;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_P1    = 2'b01,
        CELL_P2    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        DIR_H  = 2'b00,
        DIR_V  = 2'b01,
        DIR_UR = 2'b10,
        DIR_UL = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic [1:0] player_code(input logic player);
        return player ? CELL_P2 : CELL_P1;
    endfunction

endpackage

// File: rtl/connect4_win_checker_if.sv
// rtl/connect4_win_checker_if.sv - check handshake and board read port between controller and checker
interface connect4_win_checker_if
    import connect4_win_checker_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int RAW  = DEF_RAW
);
    logic                check_en;
    logic                player;
    logic                rd_en;
    logic [RAW-1:0]      rd_addr;
    logic [2*COLS-1:0]   row_data;
    logic                check_finish;
    logic                check_4;
    logic [RAW-1:0]      win_row;
    logic [2:0]          win_col;
    logic [1:0]          win_dir;

    modport master (
        output check_en, player, row_data,
        input  rd_en, rd_addr, check_finish, check_4, win_row, win_col, win_dir
    );

    modport slave (
        input  check_en, player, row_data,
        output rd_en, rd_addr, check_finish, check_4, win_row, win_col, win_dir
    );
endinterface

// File: rtl/connect4_line_detect.sv
// rtl/connect4_line_detect.sv - combinational four-in-a-row search over three stored rows plus the incoming row
module connect4_line_detect
    import connect4_win_checker_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  logic [2:0][2*COLS-1:0] window,
    input  logic [2*COLS-1:0]      row_in,
    input  logic                   full,
    input  logic [1:0]             code,
    output logic                   hit,
    output logic [2:0]             col,
    output logic [1:0]             row_back,
    output logic [1:0]             dir
);
    // rows[0] is the oldest (r-3), rows[3] the incoming row r
    logic [3:0][2*COLS-1:0] rows;
    logic [3:0][COLS-1:0]   match;

    assign rows = {row_in, window};

    always_comb begin
        match = '0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < COLS; c++) begin
                match[k][c] = (rows[k][2*c +: 2] == code);
            end
        end
    end

    // Scan lowest priority first and highest column first so the last write
    // is the highest-priority direction at its lowest column.
    always_comb begin
        hit      = 1'b0;
        col      = 3'd0;
        row_back = 2'd0;
        dir      = DIR_H;
        if (full) begin
            for (int c = COLS - 4; c >= 0; c--) begin
                if (match[0][c+3] && match[1][c+2] && match[2][c+1] && match[3][c]) begin
                    hit      = 1'b1;
                    col      = 3'(c + 3);
                    row_back = 2'd3;
                    dir      = DIR_UL;
                end
            end
            for (int c = COLS - 4; c >= 0; c--) begin
                if (match[0][c] && match[1][c+1] && match[2][c+2] && match[3][c+3]) begin
                    hit      = 1'b1;
                    col      = 3'(c);
                    row_back = 2'd3;
                    dir      = DIR_UR;
                end
            end
            for (int c = COLS - 1; c >= 0; c--) begin
                if (match[0][c] && match[1][c] && match[2][c] && match[3][c]) begin
                    hit      = 1'b1;
                    col      = 3'(c);
                    row_back = 2'd3;
                    dir      = DIR_V;
                end
            end
        end
        for (int c = COLS - 4; c >= 0; c--) begin
            if (match[3][c] && match[3][c+1] && match[3][c+2] && match[3][c+3]) begin
                hit      = 1'b1;
                col      = 3'(c);
                row_back = 2'd0;
                dir      = DIR_H;
            end
        end
    end

endmodule

// File: rtl/connect4_win_checker.sv
// rtl/connect4_win_checker.sv - row-serial board scan that reports a four-in-a-row for the moving player
module connect4_win_checker
    import connect4_win_checker_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int RAW  = DEF_RAW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    connect4_win_checker_if.slave   bus
);
    state_t                  state;
    logic [1:0]              code;
    logic                    rd_en;
    logic [RAW-1:0]          rd_addr;
    logic                    pend;
    logic [RAW-1:0]          cnt;
    logic [2:0][2*COLS-1:0]  window;
    logic                    check_finish;
    logic                    check_4;
    logic [RAW-1:0]          win_row;
    logic [2:0]              win_col;
    logic [1:0]              win_dir;

    logic                    hit;
    logic [2:0]              hit_col;
    logic [1:0]              hit_back;
    logic [1:0]              hit_dir;

    connect4_line_detect #(.COLS(COLS)) u_detect (
        .window   (window),
        .row_in   (bus.row_data),
        .full     (cnt >= RAW'(3)),
        .code     (code),
        .hit      (hit),
        .col      (hit_col),
        .row_back (hit_back),
        .dir      (hit_dir)
    );

    // pend marks that the memory is presenting the row for address cnt this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            code         <= CELL_P1;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            pend         <= 1'b0;
            cnt          <= '0;
            window       <= '0;
            check_finish <= 1'b0;
            check_4      <= 1'b0;
            win_row      <= '0;
            win_col      <= 3'd0;
            win_dir      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.check_en) begin
                        state   <= SCAN;
                        code    <= player_code(bus.player);
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        pend    <= 1'b0;
                        cnt     <= '0;
                        window  <= '0;
                        win_row <= '0;
                        win_col <= 3'd0;
                        win_dir <= 2'd0;
                    end
                end
                SCAN: begin
                    if (!bus.check_en) begin
                        state   <= IDLE;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        pend    <= 1'b0;
                        cnt     <= '0;
                        window  <= '0;
                    end else begin
                        pend <= rd_en;
                        if (rd_en) begin
                            if (rd_addr == RAW'(ROWS - 1)) begin
                                rd_en <= 1'b0;
                            end else begin
                                rd_addr <= rd_addr + RAW'(1);
                            end
                        end
                        if (pend) begin
                            window <= {bus.row_data, window[2], window[1]};
                            cnt    <= cnt + RAW'(1);
                            if (hit) begin
                                state        <= DONE;
                                check_4      <= 1'b1;
                                check_finish <= 1'b1;
                                win_row      <= cnt - RAW'(hit_back);
                                win_col      <= hit_col;
                                win_dir      <= hit_dir;
                                rd_en        <= 1'b0;
                                pend         <= 1'b0;
                            end else if (cnt == RAW'(ROWS - 1)) begin
                                state        <= DONE;
                                check_finish <= 1'b1;
                                pend         <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!bus.check_en) begin
                        state        <= IDLE;
                        check_finish <= 1'b0;
                        check_4      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_en        = rd_en;
    assign bus.rd_addr      = rd_addr;
    assign bus.check_finish = check_finish;
    assign bus.check_4      = check_4;
    assign bus.win_row      = win_row;
    assign bus.win_col      = win_col;
    assign bus.win_dir      = win_dir;

endmodule

// File: tb/tb_connect4_win_checker.sv
// tb/tb_connect4_win_checker.sv - directed and randomized board checks against a rule-level reference model
module tb_connect4_win_checker;
    import connect4_win_checker_pkg::*;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int RAW  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    connect4_win_checker_if #(.COLS(COLS), .RAW(RAW)) bus();

    connect4_win_checker #(.ROWS(ROWS), .COLS(COLS), .RAW(RAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [1:0] board [ROWS][COLS];
    int compared = 0;
    int mismatched = 0;

    function automatic logic [2*COLS-1:0] row_word(input int r);
        logic [2*COLS-1:0] w;
        w = '0;
        if (r < ROWS) begin
            for (int c = 0; c < COLS; c++) w[2*c +: 2] = board[r][c];
        end
        return w;
    endfunction

    // synchronous board memory: data for the sampled address appears after the edge
    always @(posedge clk) begin
        if (bus.rd_en) bus.row_data <= row_word(int'(bus.rd_addr));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_board();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) board[r][c] = 2'b00;
    endtask

    function automatic bit cell_is(input int r, input int c, input logic [1:0] code);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
        return board[r][c] == code;
    endfunction

    // Rows are examined bottom-up as the scan sees them; the first row that
    // completes any line decides, with the direction/column priority applied there.
    task automatic ref_model(input int p, output bit win, output int wr, output int wc,
                             output int wd, output int cap_r);
        logic [1:0] code;
        code = (p != 0) ? 2'b10 : 2'b01;
        win = 0; wr = 0; wc = 0; wd = 0; cap_r = 0;
        for (int r = 0; r < ROWS && !win; r++) begin
            for (int c = 0; c <= COLS - 4 && !win; c++)
                if (cell_is(r, c, code) && cell_is(r, c+1, code) && cell_is(r, c+2, code) && cell_is(r, c+3, code)) begin
                    win = 1; wr = r; wc = c; wd = 0; cap_r = r;
                end
            if (r >= 3) begin
                for (int c = 0; c < COLS && !win; c++)
                    if (cell_is(r-3, c, code) && cell_is(r-2, c, code) && cell_is(r-1, c, code) && cell_is(r, c, code)) begin
                        win = 1; wr = r - 3; wc = c; wd = 1; cap_r = r;
                    end
                for (int c = 0; c <= COLS - 4 && !win; c++)
                    if (cell_is(r-3, c, code) && cell_is(r-2, c+1, code) && cell_is(r-1, c+2, code) && cell_is(r, c+3, code)) begin
                        win = 1; wr = r - 3; wc = c; wd = 2; cap_r = r;
                    end
                for (int c = 0; c <= COLS - 4 && !win; c++)
                    if (cell_is(r-3, c+3, code) && cell_is(r-2, c+2, code) && cell_is(r-1, c+1, code) && cell_is(r, c, code)) begin
                        win = 1; wr = r - 3; wc = c + 3; wd = 3; cap_r = r;
                    end
            end
        end
    endtask

    // Controller model: raise check_en, follow edges E0.., drop check_en as soon as the result shows.
    task automatic run_check(input int p, input string name);
        bit win;
        int wr, wc, wd, cr, end_e;
        ref_model(p, win, wr, wc, wd, cr);
        end_e = win ? cr + 2 : ROWS + 1;
        @(negedge clk);
        bus.check_en = 1'b1;
        bus.player   = p[0];
        for (int k = 0; k <= end_e + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) bus.player = ~p[0];
            if (k < end_e) begin
                chk({name, ".finish_early"}, bus.check_finish, 0);
                chk({name, ".check4_early"}, bus.check_4, 0);
                chk({name, ".rd_en"}, bus.rd_en, (k < ROWS) ? 1 : 0);
                if (k < ROWS) chk({name, ".rd_addr"}, bus.rd_addr, k);
            end else if (k == end_e) begin
                chk({name, ".finish"}, bus.check_finish, 1);
                chk({name, ".check4"}, bus.check_4, win ? 1 : 0);
                chk({name, ".rd_en_off"}, bus.rd_en, 0);
                chk({name, ".win_row"}, bus.win_row, wr);
                chk({name, ".win_col"}, bus.win_col, wc);
                chk({name, ".win_dir"}, bus.win_dir, wd);
                bus.check_en = 1'b0;
            end else begin
                chk({name, ".finish_drop"}, bus.check_finish, 0);
                chk({name, ".check4_drop"}, bus.check_4, 0);
                chk({name, ".win_row_hold"}, bus.win_row, wr);
                chk({name, ".win_col_hold"}, bus.win_col, wc);
                chk({name, ".win_dir_hold"}, bus.win_dir, wd);
            end
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".rd_en"}, bus.rd_en, 0);
        chk({name, ".rd_addr"}, bus.rd_addr, 0);
        chk({name, ".finish"}, bus.check_finish, 0);
        chk({name, ".check4"}, bus.check_4, 0);
        chk({name, ".win_row"}, bus.win_row, 0);
        chk({name, ".win_col"}, bus.win_col, 0);
        chk({name, ".win_dir"}, bus.win_dir, 0);
    endtask

    initial begin
        bus.check_en = 1'b0;
        bus.player   = 1'b0;
        clear_board();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // empty board
        run_check(0, "empty");

        // horizontal on the bottom row
        clear_board();
        for (int c = 2; c <= 5; c++) board[0][c] = 2'b01;
        run_check(0, "horiz_row0");

        // vertical in the last column, both players
        clear_board();
        for (int r = 1; r <= 4; r++) board[r][6] = 2'b10;
        run_check(1, "vert_p1");
        run_check(0, "vert_p0");

        // diagonal up-left coexisting with a horizontal on row 3
        clear_board();
        board[0][4] = 2'b01; board[1][3] = 2'b01; board[2][2] = 2'b01;
        for (int c = 1; c <= 4; c++) board[3][c] = 2'b01;
        run_check(0, "prio_h_over_ul");

        // abort after E3, then a complete rescan
        @(negedge clk);
        bus.check_en = 1'b1;
        bus.player   = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort.rd_en", bus.rd_en, 1);
            chk("abort.rd_addr", bus.rd_addr, k);
        end
        bus.check_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort.rd_en_off", bus.rd_en, 0);
            chk("abort.finish", bus.check_finish, 0);
            chk("abort.check4", bus.check_4, 0);
        end
        run_check(0, "rescan");

        // asynchronous reset mid-scan on a winning board
        clear_board();
        for (int r = 1; r <= 4; r++) board[r][6] = 2'b10;
        @(negedge clk);
        bus.check_en = 1'b1;
        bus.player   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        bus.check_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_check(1, "after_reset");

        // random boards including the unused 2'b11 code
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    int v;
                    v = $urandom_range(0, 9);
                    board[r][c] = (v < 4) ? 2'b00 : (v < 7) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
                end
            run_check($urandom_range(0, 1), $sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
